// File: rtl/gpr_dependency_scoreboard.sv
// Per-wavefront operand dependency scoreboard: decode clears bits for pending operands,
// retire channels set them back, and a slot is ready once all of its bits are 1.
module gpr_dependency_scoreboard #(
  parameter int NUM_WF     = 40,
  parameter int WFID_W     = 6,
  parameter int DEP_BITS   = 8,
  parameter int NUM_SET_CH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SET_CH*WFID_W-1:0]   set_wfid,
  input  logic [NUM_SET_CH*DEP_BITS-1:0] set_data,
  input  logic                           decode_valid,
  input  logic [WFID_W-1:0]              decode_wfid,
  input  logic [DEP_BITS-1:0]            decode_data,
  input  logic                           flush_valid,
  input  logic [WFID_W-1:0]              flush_wfid,
  output logic [NUM_WF-1:0]              ready_arry_gpr,
  output logic                           err_valid,
  output logic [1:0]                     err_code,
  output logic [WFID_W-1:0]              err_wfid
);
  localparam logic [WFID_W:0] WF_LIMIT  = (WFID_W+1)'(NUM_WF);
  localparam logic [1:0]      ERR_DCLR  = 2'b01;
  localparam logic [1:0]      ERR_DSET  = 2'b10;
  localparam logic [1:0]      ERR_RANGE = 2'b11;

  logic [DEP_BITS-1:0]   state_q [NUM_WF];
  logic [DEP_BITS-1:0]   state_d [NUM_WF];
  logic [NUM_SET_CH-1:0] ch_oor;
  logic [NUM_SET_CH-1:0] ch_dset;
  logic                  dec_oor;
  logic                  flush_oor;
  logic                  dec_dclr;
  logic                  err_hit;
  logic [1:0]            err_code_d;
  logic [WFID_W-1:0]     err_wfid_d;

  always_comb begin
    ch_oor = '0;
    for (int k = 0; k < NUM_SET_CH; k++) begin
      ch_oor[k] = (|set_data[k*DEP_BITS +: DEP_BITS]) &&
                  ({1'b0, set_wfid[k*WFID_W +: WFID_W]} >= WF_LIMIT);
    end
    dec_oor   = decode_valid && ({1'b0, decode_wfid} >= WF_LIMIT);
    flush_oor = flush_valid && ({1'b0, flush_wfid} >= WF_LIMIT);
  end

  // A set restoring a bit that decode clears this same cycle is a legal retire, not a double set.
  always_comb begin
    logic                dec_hit;
    logic                flush_hit;
    logic [DEP_BITS-1:0] clr;
    logic [DEP_BITS-1:0] ch_set;
    ch_dset   = '0;
    dec_dclr  = 1'b0;
    dec_hit   = 1'b0;
    flush_hit = 1'b0;
    clr       = '0;
    ch_set    = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      dec_hit   = decode_valid && (decode_wfid == WFID_W'(w));
      flush_hit = flush_valid && (flush_wfid == WFID_W'(w));
      clr       = dec_hit ? decode_data : '0;
      ch_set    = '0;
      for (int k = 0; k < NUM_SET_CH; k++) begin
        if (set_wfid[k*WFID_W +: WFID_W] == WFID_W'(w)) begin
          ch_set = ch_set | set_data[k*DEP_BITS +: DEP_BITS];
          if (!flush_hit && (|(set_data[k*DEP_BITS +: DEP_BITS] & state_q[w] & ~clr)))
            ch_dset[k] = 1'b1;
        end
      end
      if (dec_hit && (|(clr & ~state_q[w] & ~ch_set)))
        dec_dclr = 1'b1;
      state_d[w] = flush_hit ? '1 :
                   ((state_q[w] & ~clr) | ch_set | (dec_hit ? ~decode_data : '0));
    end
  end

  // Same-cycle error arbitration: range, then double clear, then double set by channel order.
  always_comb begin
    err_hit    = 1'b0;
    err_code_d = '0;
    err_wfid_d = '0;
    for (int k = 0; k < NUM_SET_CH; k++) begin
      if (!err_hit && ch_oor[k]) begin
        err_hit    = 1'b1;
        err_code_d = ERR_RANGE;
        err_wfid_d = set_wfid[k*WFID_W +: WFID_W];
      end
    end
    if (!err_hit && dec_oor) begin
      err_hit    = 1'b1;
      err_code_d = ERR_RANGE;
      err_wfid_d = decode_wfid;
    end
    if (!err_hit && flush_oor) begin
      err_hit    = 1'b1;
      err_code_d = ERR_RANGE;
      err_wfid_d = flush_wfid;
    end
    if (!err_hit && dec_dclr) begin
      err_hit    = 1'b1;
      err_code_d = ERR_DCLR;
      err_wfid_d = decode_wfid;
    end
    for (int k = 0; k < NUM_SET_CH; k++) begin
      if (!err_hit && ch_dset[k]) begin
        err_hit    = 1'b1;
        err_code_d = ERR_DSET;
        err_wfid_d = set_wfid[k*WFID_W +: WFID_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WF; w++) state_q[w] <= '1;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_wfid  <= '0;
    end else begin
      for (int w = 0; w < NUM_WF; w++) state_q[w] <= state_d[w];
      if (!err_valid && err_hit) begin
        err_valid <= 1'b1;
        err_code  <= err_code_d;
        err_wfid  <= err_wfid_d;
      end
    end
  end

  always_comb begin
    ready_arry_gpr = '0;
    for (int w = 0; w < NUM_WF; w++) ready_arry_gpr[w] = &state_q[w];
  end
endmodule

// File: tb/tb_gpr_dependency_scoreboard.sv
// Bench for gpr_dependency_scoreboard: directed scenarios plus randomized traffic
// compared against a per-bit behavioural model of the scoreboard.
module tb_gpr_dependency_scoreboard;
  localparam int NUM_WF     = 40;
  localparam int WFID_W     = 6;
  localparam int DEP_BITS   = 8;
  localparam int NUM_SET_CH = 5;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_SET_CH*WFID_W-1:0]   set_wfid;
  logic [NUM_SET_CH*DEP_BITS-1:0] set_data;
  logic                           decode_valid;
  logic [WFID_W-1:0]              decode_wfid;
  logic [DEP_BITS-1:0]            decode_data;
  logic                           flush_valid;
  logic [WFID_W-1:0]              flush_wfid;
  logic [NUM_WF-1:0]              ready_arry_gpr;
  logic                           err_valid;
  logic [1:0]                     err_code;
  logic [WFID_W-1:0]              err_wfid;

  int checks = 0;
  int errors = 0;

  logic [DEP_BITS-1:0] m_state [NUM_WF];
  logic [DEP_BITS-1:0] m_next  [NUM_WF];
  logic                m_err_valid;
  logic [1:0]          m_err_code;
  logic [WFID_W-1:0]   m_err_wfid;
  logic                p_found;
  logic [1:0]          p_code;
  logic [WFID_W-1:0]   p_wfid;

  always #5 clk = ~clk;

  gpr_dependency_scoreboard #(
    .NUM_WF(NUM_WF), .WFID_W(WFID_W), .DEP_BITS(DEP_BITS), .NUM_SET_CH(NUM_SET_CH)
  ) dut (
    .clk(clk), .rst(rst),
    .set_wfid(set_wfid), .set_data(set_data),
    .decode_valid(decode_valid), .decode_wfid(decode_wfid), .decode_data(decode_data),
    .flush_valid(flush_valid), .flush_wfid(flush_wfid),
    .ready_arry_gpr(ready_arry_gpr),
    .err_valid(err_valid), .err_code(err_code), .err_wfid(err_wfid)
  );

  task automatic clear_inputs();
    set_wfid     = '0;
    set_data     = '0;
    decode_valid = 1'b0;
    decode_wfid  = '0;
    decode_data  = '0;
    flush_valid  = 1'b0;
    flush_wfid   = '0;
  endtask

  task automatic set_ch(input int k, input int wfid, input logic [DEP_BITS-1:0] data);
    set_wfid[k*WFID_W +: WFID_W]     = WFID_W'(wfid);
    set_data[k*DEP_BITS +: DEP_BITS] = data;
  endtask

  task automatic do_decode(input int wfid, input logic [DEP_BITS-1:0] data);
    decode_valid = 1'b1;
    decode_wfid  = WFID_W'(wfid);
    decode_data  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [NUM_WF-1:0] ready_except(input int a, input int b);
    logic [NUM_WF-1:0] r;
    r = '1;
    if (a >= 0) r[a] = 1'b0;
    if (b >= 0) r[b] = 1'b0;
    return r;
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic int chw(input int k);
    return int'(set_wfid[k*WFID_W +: WFID_W]);
  endfunction

  function automatic logic [DEP_BITS-1:0] chd(input int k);
    return set_data[k*DEP_BITS +: DEP_BITS];
  endfunction

  function automatic bit chan_sets(input int w, input int b);
    logic [DEP_BITS-1:0] d;
    for (int k = 0; k < NUM_SET_CH; k++) begin
      d = chd(k);
      if (chw(k) == w && d[b]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NUM_WF; w++) m_state[w] = '1;
    m_err_valid = 1'b0;
    m_err_code  = '0;
    m_err_wfid  = '0;
  endtask

  task automatic model_step();
    int dw;
    int fw;
    bit dec_in;
    bit dec_hit;
    logic [DEP_BITS-1:0] d;
    dw      = int'(decode_wfid);
    fw      = int'(flush_wfid);
    dec_in  = decode_valid && dw < NUM_WF;
    p_found = 1'b0;
    p_code  = '0;
    p_wfid  = '0;
    for (int k = 0; k < NUM_SET_CH; k++)
      if (!p_found && chd(k) != 0 && chw(k) >= NUM_WF) begin
        p_found = 1'b1; p_code = 2'b11; p_wfid = WFID_W'(chw(k));
      end
    if (!p_found && decode_valid && dw >= NUM_WF) begin
      p_found = 1'b1; p_code = 2'b11; p_wfid = WFID_W'(dw);
    end
    if (!p_found && flush_valid && fw >= NUM_WF) begin
      p_found = 1'b1; p_code = 2'b11; p_wfid = WFID_W'(fw);
    end
    if (dec_in)
      for (int b = 0; b < DEP_BITS; b++)
        if (!p_found && decode_data[b] && !m_state[dw][b] && !chan_sets(dw, b)) begin
          p_found = 1'b1; p_code = 2'b01; p_wfid = WFID_W'(dw);
        end
    for (int k = 0; k < NUM_SET_CH; k++) begin
      d = chd(k);
      if (chw(k) < NUM_WF && !(flush_valid && fw == chw(k)))
        for (int b = 0; b < DEP_BITS; b++)
          if (!p_found && d[b] && m_state[chw(k)][b] &&
              !(dec_in && dw == chw(k) && decode_data[b])) begin
            p_found = 1'b1; p_code = 2'b10; p_wfid = WFID_W'(chw(k));
          end
    end
    for (int w = 0; w < NUM_WF; w++) begin
      dec_hit = decode_valid && dw == w;
      for (int b = 0; b < DEP_BITS; b++) begin
        if (flush_valid && fw == w)                      m_next[w][b] = 1'b1;
        else if (chan_sets(w, b))                        m_next[w][b] = 1'b1;
        else if (dec_hit && !decode_data[b])             m_next[w][b] = 1'b1;
        else if (dec_hit && decode_data[b])              m_next[w][b] = 1'b0;
        else                                             m_next[w][b] = m_state[w][b];
      end
    end
  endtask

  task automatic model_commit();
    for (int w = 0; w < NUM_WF; w++) m_state[w] = m_next[w];
    if (!m_err_valid && p_found) begin
      m_err_valid = 1'b1;
      m_err_code  = p_code;
      m_err_wfid  = p_wfid;
    end
  endtask

  function automatic int rand_wfid();
    if ($urandom_range(0, 11) == 0) return int'($urandom_range(NUM_WF, 63));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic randomize_inputs();
    clear_inputs();
    for (int k = 0; k < NUM_SET_CH; k++)
      if ($urandom_range(0, 99) < 30) set_ch(k, rand_wfid(), DEP_BITS'($urandom) & DEP_BITS'($urandom));
    if ($urandom_range(0, 99) < 50) do_decode(rand_wfid(), DEP_BITS'($urandom));
    if ($urandom_range(0, 99) < 12) begin
      flush_valid = 1'b1;
      flush_wfid  = WFID_W'(rand_wfid());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL reset_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_valid: got %b expected 0", err_valid); end
    checks++;
    if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_code: got %b expected 00", err_code); end
    checks++;
    if (err_wfid !== '0) begin errors++; $display("[TB] FAIL reset_err_wfid: got %0d expected 0", err_wfid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode_clear();
    do_decode(3, 8'h05);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== ready_except(3, -1)) begin errors++; $display("[TB] FAIL decode_clear_ready: got %h expected %h", ready_arry_gpr, ready_except(3, -1)); end
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL decode_clear_err: got %b expected 0", err_valid); end
  endtask

  task automatic test_multi_set();
    set_ch(0, 3, 8'h01);
    set_ch(4, 3, 8'h04);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL multi_set_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL multi_set_err: got %b expected 0", err_valid); end
  endtask

  task automatic test_set_clear_same();
    do_decode(7, 8'h02);
    set_ch(1, 7, 8'h02);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL set_clear_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL set_clear_err: got %b expected 0", err_valid); end
  endtask

  task automatic test_flush_override();
    do_decode(9, 8'hFF);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== ready_except(9, -1)) begin errors++; $display("[TB] FAIL flush_pre_ready: got %h expected %h", ready_arry_gpr, ready_except(9, -1)); end
    do_decode(9, 8'hFF);
    flush_valid = 1'b1;
    flush_wfid  = 6'd9;
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL flush_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b01, 6'd9}) begin errors++; $display("[TB] FAIL flush_dclr_err: got %b/%b/%0d expected 1/01/9", err_valid, err_code, err_wfid); end
    do_reset();
  endtask

  task automatic test_out_of_range();
    do_decode(45, 8'h0F);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL oor_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b11, 6'd45}) begin errors++; $display("[TB] FAIL oor_err: got %b/%b/%0d expected 1/11/45", err_valid, err_code, err_wfid); end
    do_decode(2, 8'hFF);
    tick();
    do_decode(2, 8'hFF);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== ready_except(2, -1)) begin errors++; $display("[TB] FAIL oor_later_ready: got %h expected %h", ready_arry_gpr, ready_except(2, -1)); end
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b11, 6'd45}) begin errors++; $display("[TB] FAIL oor_sticky: got %b/%b/%0d expected 1/11/45", err_valid, err_code, err_wfid); end
    do_reset();
  endtask

  task automatic test_error_priority();
    do_decode(4, 8'h01);
    tick();
    clear_inputs();
    set_ch(3, 1, 8'h01);
    set_ch(1, 0, 8'h01);
    do_decode(4, 8'h01);
    tick();
    clear_inputs();
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b01, 6'd4}) begin errors++; $display("[TB] FAIL prio_dclr_over_dset: got %b/%b/%0d expected 1/01/4", err_valid, err_code, err_wfid); end
    checks++;
    if (ready_arry_gpr !== ready_except(4, -1)) begin errors++; $display("[TB] FAIL prio_ready: got %h expected %h", ready_arry_gpr, ready_except(4, -1)); end
    do_reset();
    set_ch(3, 1, 8'h01);
    set_ch(1, 0, 8'h02);
    tick();
    clear_inputs();
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b10, 6'd0}) begin errors++; $display("[TB] FAIL prio_low_channel: got %b/%b/%0d expected 1/10/0", err_valid, err_code, err_wfid); end
    do_reset();
    set_ch(0, 1, 8'h01);
    set_ch(4, 50, 8'h01);
    tick();
    clear_inputs();
    checks++;
    if ({err_valid, err_code, err_wfid} !== {1'b1, 2'b11, 6'd50}) begin errors++; $display("[TB] FAIL prio_range_first: got %b/%b/%0d expected 1/11/50", err_valid, err_code, err_wfid); end
    do_reset();
    set_ch(0, 5, 8'hFF);
    flush_valid = 1'b1;
    flush_wfid  = 6'd5;
    tick();
    clear_inputs();
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_masks_dset: got %b expected 0", err_valid); end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_decode(6, 8'hFF);
    tick();
    clear_inputs();
    do_decode(50, 8'h01);
    tick();
    clear_inputs();
    checks++;
    if (ready_arry_gpr !== ready_except(6, -1) || err_valid !== 1'b1) begin errors++; $display("[TB] FAIL async_pre: got %h/%b expected %h/1", ready_arry_gpr, err_valid, ready_except(6, -1)); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ready_arry_gpr !== {NUM_WF{1'b1}}) begin errors++; $display("[TB] FAIL async_ready: got %h expected %h", ready_arry_gpr, {NUM_WF{1'b1}}); end
    checks++;
    if ({err_valid, err_code, err_wfid} !== 9'd0) begin errors++; $display("[TB] FAIL async_err: got %b/%b/%0d expected 0/00/0", err_valid, err_code, err_wfid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [NUM_WF-1:0] exp_ready;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      model_reset();
      for (int i = 0; i < 60; i++) begin
        randomize_inputs();
        model_step();
        tick();
        model_commit();
        for (int w = 0; w < NUM_WF; w++) exp_ready[w] = &m_state[w];
        checks++;
        if (ready_arry_gpr !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready blk%0d cyc%0d: got %h expected %h", blk, i, ready_arry_gpr, exp_ready); end
        checks++;
        if ({err_valid, err_code, err_wfid} !== {m_err_valid, m_err_code, m_err_wfid}) begin
          errors++;
          $display("[TB] FAIL rand_err blk%0d cyc%0d: got %b/%b/%0d expected %b/%b/%0d", blk, i, err_valid, err_code, err_wfid, m_err_valid, m_err_code, m_err_wfid);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_decode_clear();
    test_multi_set();
    test_set_clear_same();
    test_flush_override();
    test_out_of_range();
    test_error_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
